// File: rtl/up_axi_master.sv
// Up-bus request/ack to AXI4-Lite master bridge; one write and one read in flight, one buffered read.
// Optional feature: UP_AXI_MASTER_RESP_CHECK_EN reports non-OKAY bresp/rresp on up_err.
module up_axi_master #(
  parameter int ADDRESS_WIDTH     = 14,
  parameter int AXI_ADDRESS_WIDTH = 16
) (
  input  logic                         up_clk,
  input  logic                         up_rst,

  input  logic                         up_wreq,
  input  logic [ADDRESS_WIDTH-1:0]     up_waddr,
  input  logic [31:0]                  up_wdata,
  output logic                         up_wack,
  input  logic                         up_rreq,
  input  logic [ADDRESS_WIDTH-1:0]     up_raddr,
  output logic [31:0]                  up_rdata,
  output logic                         up_rack,
  output logic                         up_err,

  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  output logic [31:0]                  m_axi_wdata,
  output logic [3:0]                   m_axi_wstrb,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  input  logic [1:0]                   m_axi_bresp,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic [31:0]                  m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp
);

  // state     | meaning
  // S_IDLE    | no transaction, accepts write (priority) or read
  // S_WR      | AW and W offered, each drops on its own handshake
  // S_WR_RESP | bready high, waiting for bvalid
  // S_RD      | AR offered
  // S_RD_RESP | rready high, waiting for rvalid
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD,
    S_RD_RESP
  } state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;

  logic                           r_awvalid, w_awvalid_nxt;
  logic [AXI_ADDRESS_WIDTH-1:0]   r_awaddr,  w_awaddr_nxt;
  logic                           r_wvalid,  w_wvalid_nxt;
  logic [31:0]                    r_wdata,   w_wdata_nxt;
  logic                           r_bready,  w_bready_nxt;
  logic                           r_arvalid, w_arvalid_nxt;
  logic [AXI_ADDRESS_WIDTH-1:0]   r_araddr,  w_araddr_nxt;
  logic                           r_rready,  w_rready_nxt;
  logic                           r_pend_vld, w_pend_vld_nxt;
  logic [ADDRESS_WIDTH-1:0]       r_pend_addr, w_pend_addr_nxt;
  logic                           r_wack,    w_wack_nxt;
  logic                           r_rack,    w_rack_nxt;
  logic                           r_err,     w_err_nxt;
  logic [31:0]                    r_rdata,   w_rdata_nxt;

  logic                           w_rd_want;
  logic [ADDRESS_WIDTH-1:0]       w_rd_addr;
  logic                           w_launch_rd;
  logic                           w_aw_done;
  logic                           w_w_done;

  function automatic logic [AXI_ADDRESS_WIDTH-1:0] f_byte_addr(input logic [ADDRESS_WIDTH-1:0] a);
    return AXI_ADDRESS_WIDTH'({a, 2'b00});
  endfunction

  // The buffered read always wins over a fresh one; the requester contract keeps them exclusive.
  assign w_rd_want = r_pend_vld | up_rreq;
  assign w_rd_addr = r_pend_vld ? r_pend_addr : up_raddr;
  assign w_aw_done = ~r_awvalid | m_axi_awready;
  assign w_w_done  = ~r_wvalid  | m_axi_wready;

  always_comb begin
    w_state_nxt     = r_state;
    w_awvalid_nxt   = r_awvalid;
    w_awaddr_nxt    = r_awaddr;
    w_wvalid_nxt    = r_wvalid;
    w_wdata_nxt     = r_wdata;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_araddr_nxt    = r_araddr;
    w_rready_nxt    = r_rready;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_wack_nxt      = 1'b0;
    w_rack_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_rdata_nxt     = 32'h0;
    w_launch_rd     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (up_wreq) begin
          w_state_nxt   = S_WR;
          w_awvalid_nxt = 1'b1;
          w_awaddr_nxt  = f_byte_addr(up_waddr);
          w_wvalid_nxt  = 1'b1;
          w_wdata_nxt   = up_wdata;
        end else if (w_rd_want) begin
          w_launch_rd = 1'b1;
        end
      end
      S_WR: begin
        if (m_axi_awready) begin
          w_awvalid_nxt = 1'b0;
          w_awaddr_nxt  = '0;
        end
        if (m_axi_wready) begin
          w_wvalid_nxt = 1'b0;
          w_wdata_nxt  = 32'h0;
        end
        if (w_aw_done && w_w_done) begin
          w_state_nxt  = S_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_nxt = 1'b0;
          w_wack_nxt   = 1'b1;
`ifdef UP_AXI_MASTER_RESP_CHECK_EN
          w_err_nxt    = (m_axi_bresp != 2'b00);
`else
          w_err_nxt    = |(m_axi_bresp & 2'b00);
`endif
          w_state_nxt  = S_IDLE;
          w_launch_rd  = w_rd_want;
        end
      end
      S_RD: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_araddr_nxt  = '0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axi_rvalid) begin
          w_rready_nxt = 1'b0;
          w_rack_nxt   = 1'b1;
`ifdef UP_AXI_MASTER_RESP_CHECK_EN
          w_err_nxt    = (m_axi_rresp != 2'b00);
          w_rdata_nxt  = (m_axi_rresp != 2'b00) ? 32'h0 : m_axi_rdata;
`else
          w_err_nxt    = |(m_axi_rresp & 2'b00);
          w_rdata_nxt  = m_axi_rdata;
`endif
          w_state_nxt  = S_IDLE;
          w_launch_rd  = w_rd_want;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Issuing straight out of a response state removes the idle bubble before a queued read.
    if (w_launch_rd) begin
      w_state_nxt    = S_RD;
      w_arvalid_nxt  = 1'b1;
      w_araddr_nxt   = f_byte_addr(w_rd_addr);
      w_pend_vld_nxt = 1'b0;
    end else if (up_rreq) begin
      w_pend_vld_nxt  = 1'b1;
      w_pend_addr_nxt = up_raddr;
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_awaddr    <= '0;
      r_wvalid    <= 1'b0;
      r_wdata     <= 32'h0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_rready    <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_wack      <= 1'b0;
      r_rack      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      r_state     <= w_state_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_araddr    <= w_araddr_nxt;
      r_rready    <= w_rready_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_wack      <= w_wack_nxt;
      r_rack      <= w_rack_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign up_wack       = r_wack;
  assign up_rack       = r_rack;
  assign up_err        = r_err;
  assign up_rdata      = r_rdata;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = 4'hf;
  assign m_axi_bready  = r_bready;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_up_axi_master.sv
// Directed bench for up_axi_master: latency, backpressure, priority, response errors, reset abort.
module tb_up_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        wreq, rreq;
  logic [13:0] waddr, raddr;
  logic [31:0] wdata;
  logic        wack, rack, err;
  logic [31:0] rdata_up;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, wack_cnt = 0, rack_cnt = 0;
  int s_aw, s_w, s_b, s_wack, s_rack;

  always #5 clk = ~clk;

  up_axi_master #(.ADDRESS_WIDTH(14), .AXI_ADDRESS_WIDTH(16)) dut (
    .up_clk(clk), .up_rst(rst),
    .up_wreq(wreq), .up_waddr(waddr), .up_wdata(wdata), .up_wack(wack),
    .up_rreq(rreq), .up_raddr(raddr), .up_rdata(rdata_up), .up_rack(rack), .up_err(err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(axi_wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(axi_rdata), .m_axi_rresp(rresp)
  );

  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready)   w_cnt++;
    if (bvalid && bready)   b_cnt++;
    if (arvalid && arready) ar_cnt++;
    if (rvalid && rready)   r_cnt++;
    if (wack) wack_cnt++;
    if (rack) rack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] outs_or();
    return {8'h0, awvalid, wvalid, bready, arvalid, rready, wack, rack, err} |
           32'(awaddr) | 32'(araddr) | axi_wdata | rdata_up | 32'(awprot) | 32'(arprot);
  endfunction

  initial begin
    rst = 1'b1; wreq = 0; rreq = 0; waddr = '0; raddr = '0; wdata = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; axi_rdata = 0; rresp = 0;
    repeat (3) tick();
    chk("reset_outputs", outs_or(), 32'h0);
    rst = 1'b0;
    tick();

    // basic write, everything ready
    awready = 1; wready = 1; bvalid = 1;
    s_aw = aw_cnt; s_w = w_cnt; s_b = b_cnt;
    wreq = 1; waddr = 14'h040; wdata = 32'h12345678;
    tick(); wreq = 0;
    chk("wr1_c1_awvalid", 32'(awvalid), 1);
    chk("wr1_c1_wvalid", 32'(wvalid), 1);
    chk("wr1_c1_awaddr", 32'(awaddr), 32'h0100);
    chk("wr1_c1_wdata", axi_wdata, 32'h12345678);
    chk("wr1_c1_wstrb", 32'(wstrb), 32'hf);
    tick();
    chk("wr1_c2_bready", 32'(bready), 1);
    chk("wr1_c2_valids", 32'({awvalid, wvalid}), 0);
    chk("wr1_c2_wack", 32'(wack), 0);
    tick();
    chk("wr1_c3_wack", 32'(wack), 1);
    chk("wr1_c3_bready", 32'(bready), 0);
    tick();
    chk("wr1_c4_wack", 32'(wack), 0);
    chk("wr1_beats", 32'({4'(aw_cnt - s_aw), 4'(w_cnt - s_w), 4'(b_cnt - s_b)}), 32'h111);
    tick();

    // write with delayed awready
    awready = 0; wready = 1; bvalid = 1;
    wreq = 1; waddr = 14'h123; wdata = 32'hDEADBEEF;
    tick(); wreq = 0;
    chk("wr2_c1_valids", 32'({awvalid, wvalid}), 32'h3);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) awready = 1;
      chk($sformatf("wr2_c%0d_wvalid", c), 32'(wvalid), 0);
      chk($sformatf("wr2_c%0d_awvalid", c), 32'(awvalid), 1);
      chk($sformatf("wr2_c%0d_awaddr", c), 32'(awaddr), 32'h048C);
    end
    tick();
    chk("wr2_c6_bready", 32'(bready), 1);
    chk("wr2_c6_wack", 32'(wack), 0);
    tick();
    chk("wr2_c7_wack", 32'(wack), 1);
    tick(); tick();

    // read
    arready = 1; rvalid = 1; axi_rdata = 32'hA5A50001; rresp = 2'b00;
    rreq = 1; raddr = 14'h011;
    tick(); rreq = 0;
    chk("rd1_c1_arvalid", 32'(arvalid), 1);
    chk("rd1_c1_araddr", 32'(araddr), 32'h0044);
    tick();
    chk("rd1_c2_rready", 32'(rready), 1);
    chk("rd1_c2_arvalid", 32'(arvalid), 0);
    tick();
    chk("rd1_c3_rack", 32'(rack), 1);
    chk("rd1_c3_rdata", rdata_up, 32'hA5A50001);
    tick();
    chk("rd1_c4_rack", 32'(rack), 0);
    chk("rd1_c4_rdata", rdata_up, 32'h0);
    tick();

    // simultaneous write and read
    awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; axi_rdata = 32'h0BADF00D;
    s_wack = wack_cnt; s_rack = rack_cnt;
    wreq = 1; waddr = 14'h002; wdata = 32'h55AA55AA;
    rreq = 1; raddr = 14'h3FFF;
    tick(); wreq = 0; rreq = 0;
    chk("wr_rd_c1_awvalid", 32'(awvalid), 1);
    chk("wr_rd_c1_arvalid", 32'(arvalid), 0);
    tick();
    chk("wr_rd_c2_bready", 32'(bready), 1);
    tick();
    chk("wr_rd_c3_wack", 32'(wack), 1);
    chk("wr_rd_c3_arvalid", 32'(arvalid), 1);
    chk("wr_rd_c3_araddr", 32'(araddr), 32'hFFFC);
    tick();
    chk("wr_rd_c4_rready", 32'(rready), 1);
    tick();
    chk("wr_rd_c5_rack", 32'(rack), 1);
    chk("wr_rd_c5_rdata", rdata_up, 32'h0BADF00D);
    repeat (3) tick();
    chk("wr_rd_ack_counts", 32'({8'(wack_cnt - s_wack), 8'(rack_cnt - s_rack)}), 32'h0101);

    // error responses
    bresp = 2'b11;
    wreq = 1; waddr = 14'h001; wdata = 32'h1;
    tick(); wreq = 0;
    tick(); tick();
    chk("wr_err_wack", 32'(wack), 1);
`ifdef UP_AXI_MASTER_RESP_CHECK_EN
    chk("wr_err_err", 32'(err), 1);
`else
    chk("wr_err_err", 32'(err), 0);
`endif
    bresp = 2'b00;
    tick();
    rresp = 2'b10; axi_rdata = 32'hFFFFFFFF;
    rreq = 1; raddr = 14'h005;
    tick(); rreq = 0;
    tick(); tick();
    chk("rd_err_rack", 32'(rack), 1);
`ifdef UP_AXI_MASTER_RESP_CHECK_EN
    chk("rd_err_err", 32'(err), 1);
    chk("rd_err_rdata", rdata_up, 32'h0);
`else
    chk("rd_err_err", 32'(err), 0);
    chk("rd_err_rdata", rdata_up, 32'hFFFFFFFF);
`endif
    rresp = 2'b00;
    tick(); tick();

    // reset during WR_RESP with a read pending
    awready = 1; wready = 1; bvalid = 0;
    s_wack = wack_cnt; s_rack = rack_cnt;
    wreq = 1; waddr = 14'h010; wdata = 32'hCAFE0000;
    rreq = 1; raddr = 14'h007;
    tick(); wreq = 0; rreq = 0;
    tick();
    chk("rst_c2_bready", 32'(bready), 1);
    rst = 1;
    tick();
    chk("rst_c3_outputs", outs_or(), 32'h0);
    rst = 0; bvalid = 1;
    repeat (4) begin
      tick();
      chk("rst_no_arvalid", 32'(arvalid), 0);
    end
    chk("rst_no_acks", 32'({8'(wack_cnt - s_wack), 8'(rack_cnt - s_rack)}), 32'h0);
    bvalid = 0; axi_rdata = 32'h600DCAFE;
    rreq = 1; raddr = 14'h009;
    tick(); rreq = 0;
    chk("post_rst_araddr", 32'(araddr), 32'h0024);
    tick(); tick();
    chk("post_rst_rack", 32'(rack), 1);
    chk("post_rst_rdata", rdata_up, 32'h600DCAFE);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/up_axi_master.md
# up_axi_master

AXI4-Lite initiator that converts the internal up-bus request/acknowledge protocol into AXI4-Lite master transactions. It is the initiating end of the bus that the TPL and common register maps respond on. Use it to let a local sequencer or soft controller program any register-mapped core (TPL DAC/ADC, JESD link, clock chip bridge) over AXI4-Lite. It serves one write and one read at a time, and can buffer one read request that arrives behind a write.

## Interface
Parameters:
- ADDRESS_WIDTH, 14: width of up-bus word address.
- AXI_ADDRESS_WIDTH, 16: width of AXI byte address. Must be at least ADDRESS_WIDTH+2.

Ports:
- up_clk  in  1  single clock for all logic.
- up_rst  in  1  reset. Synchronous, active-high (already decided).
- up_wreq  in  1  write request, single-cycle pulse.
- up_waddr  in  ADDRESS_WIDTH  write word address, sampled with up_wreq.
- up_wdata  in  32  write data, sampled with up_wreq.
- up_wack  out  1  write done, single-cycle pulse.
- up_rreq  in  1  read request, single-cycle pulse.
- up_raddr  in  ADDRESS_WIDTH  read word address, sampled with up_rreq.
- up_rdata  out  32  read data, valid only while up_rack=1, otherwise 0.
- up_rack  out  1  read done, single-cycle pulse.
- up_err  out  1  error response, qualifies up_wack/up_rack (see Configuration).
- m_axi_awvalid/awready  out/in  1  AW handshake.
- m_axi_awaddr  out  AXI_ADDRESS_WIDTH  write byte address.
- m_axi_awprot  out  3  constant 3'b000.
- m_axi_wvalid/wready  out/in  1  W handshake.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  constant 4'hf.
- m_axi_bvalid/bready  in/out  1  B handshake.
- m_axi_bresp  in  2  write response.
- m_axi_arvalid/arready  out/in  1  AR handshake.
- m_axi_araddr  out  AXI_ADDRESS_WIDTH  read byte address.
- m_axi_arprot  out  3  constant 3'b000.
- m_axi_rvalid/rready  in/out  1  R handshake.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.

## Operation
- Address mapping: byte address = {up_xaddr, 2'b00}, zero-extended to AXI_ADDRESS_WIDTH.
- FSM states:
  - IDLE. Goes to WR on a write request; otherwise goes to RD on a pending read or an incoming read.
  - WR. Asserts awvalid and wvalid. Each drops independently when its handshake completes. Goes to WR_RESP when both have completed, in any order or in the same cycle.
  - WR_RESP. Asserts bready. Goes to IDLE on bvalid.
  - RD. Asserts arvalid. Goes to RD_RESP on arready.
  - RD_RESP. Asserts rready. Goes to IDLE on rvalid.
- Priority:
  - up_wreq and up_rreq in the same cycle: the write is served first.
  - The read address is latched into a one-entry pending slot and served directly after the write's wack.
- up_rreq arriving while busy (any non-IDLE state) is latched into the pending slot and served after the current transaction.
- Requester contract: no new request of a type until that type's ack. A second up_wreq while busy is ignored.
- The B and R handshakes are captured in a register. up_wack/up_rack pulse in the cycle after bvalid&bready / rvalid&rready.
- From IDLE, a pending read is issued in the same cycle the FSM returns to IDLE, with no bubble cycle.
- Address/data outputs hold their value while the matching valid is high, and are 0 otherwise.

## Timing
- Reset values: every output is 0, the pending slot is empty, and the FSM is in IDLE.
- Minimum latency with all readies/valids high: request at cycle 0, AXI valids at cycle 1, bready/rready at cycle 2, ack at cycle 3.
- Valids never drop before their handshake completes (AXI rule). Valids do not depend combinationally on ready.
- bready/rready are registered and high for the whole duration of the response state.
- Reset asserted mid-transaction:
  - All outputs go to 0 on the next edge and the pending read is discarded.
  - The attached slave must share the reset.
  - No ack is produced for the aborted request.

## Configuration
- UP_AXI_MASTER_RESP_CHECK_EN defined:
  - up_err=1 in the ack cycle when the captured bresp/rresp is not 2'b00.
  - On a read error, up_rdata is forced to 0.
- Macro not defined:
  - bresp/rresp are ignored and up_err is tied to 0.
  - up_rdata always carries the captured rdata.

## Test plan
- Write of waddr 0x040, wdata 0x12345678, all readies high and bvalid immediate -> awaddr 0x0100, wstrb 4'hf, up_wack at cycle 3, one AW, one W and one B beat.
- Write with wready at cycle 1 and awready delayed to cycle 5 -> wvalid low from cycle 2, awvalid held with a stable address through cycle 5, up_wack at cycle 7.
- Read of raddr 0x011 with slave rdata 0xA5A50001 -> araddr 0x0044, up_rack at cycle 3 with up_rdata 0xA5A50001, up_rdata 0 in the following cycle.
- up_wreq and up_rreq in the same cycle -> AW/W issued first, up_wack, then arvalid in the same cycle the FSM is back in IDLE, then up_rack. Exactly one ack of each type.
- With UP_AXI_MASTER_RESP_CHECK_EN: rresp 2'b10 with rdata 0xFFFFFFFF -> up_rack=1, up_err=1, up_rdata=0. Without the macro: up_err=0, up_rdata=0xFFFFFFFF.
- up_rst asserted while in WR_RESP with a read pending -> all outputs 0 next cycle, no ack, and a new read after reset completes normally.
